alu_seq_ctrl: RTL and testbench

- Multi-cycle controller that sequences the 16-bit register-file / shifter / ALU datapath for one instruction at a time.
- Accepts an instruction over a valid/ready handshake and decodes it.
- Drives register read/write selects, operand and result load enables, mux selects and ALU_op, then pulses done.
- Sits between the instruction source and the datapath; the only block that asserts datapath control lines.

---
 rtl/alu_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle control FSM for the 16-bit regfile/shifter/ALU datapath.
// Optional SEQ_BACK2BACK_EN: accept the next instruction in the done cycle.
module alu_seq_ctrl #(
  parameter int NREG = 8,
  localparam int RW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [RW-1:0] readnum,
  output logic [RW-1:0] writenum,
  output logic          write,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    vsel,
  output logic [1:0]    ALU_op,
  output logic [1:0]    shift,
  output logic [15:0]   sximm8,
  output logic          done,
  output logic          illegal
);

`ifdef SEQ_BACK2BACK_EN
  localparam logic LP_B2B = 1'b1;
`else
  localparam logic LP_B2B = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GETA, S_GETB,
    S_EXEC, S_WRC, S_WIMM
  } state_t;

  state_t      r_state;
  state_t      w_next;
  state_t      w_fin;
  logic [15:0] r_instr;

  logic [2:0]    w_opc;
  logic [1:0]    w_op;
  logic [RW-1:0] w_rn;
  logic [RW-1:0] w_rd;
  logic [RW-1:0] w_rm;
  logic w_movi, w_movr, w_add, w_cmp, w_and, w_mvn;

  assign w_opc  = r_instr[15:13];
  assign w_op   = r_instr[12:11];
  assign w_rn   = r_instr[8 +: RW];
  assign w_rd   = r_instr[5 +: RW];
  assign w_rm   = r_instr[0 +: RW];
  assign w_movi = (w_opc == 3'b110) && (w_op == 2'b10);
  assign w_movr = (w_opc == 3'b110) && (w_op == 2'b00);
  assign w_add  = (w_opc == 3'b101) && (w_op == 2'b00);
  assign w_cmp  = (w_opc == 3'b101) && (w_op == 2'b01);
  assign w_and  = (w_opc == 3'b101) && (w_op == 2'b10);
  assign w_mvn  = (w_opc == 3'b101) && (w_op == 2'b11);

  assign shift  = r_instr[4:3];
  assign sximm8 = {{8{r_instr[7]}}, r_instr[7:0]};

  // Done cycles chain straight into DECODE when a transfer lands there.
  assign w_fin = (LP_B2B && instr_valid) ? S_DECODE : S_WAIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT;
      r_instr <= '0;
    end else begin
      r_state <= w_next;
      if (instr_valid && instr_ready) r_instr <= instr;
    end
  end

  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    readnum     = '0;
    writenum    = '0;
    write       = 1'b0;
    loada       = 1'b0;
    loadb       = 1'b0;
    loadc       = 1'b0;
    loads       = 1'b0;
    asel        = 1'b0;
    bsel        = 1'b0;
    vsel        = 2'b00;
    ALU_op      = 2'b00;
    done        = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      S_WAIT: begin
        instr_ready = 1'b1;
        if (instr_valid) w_next = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          w_movi:                 w_next = S_WIMM;
          (w_movr | w_mvn):       w_next = S_GETB;
          (w_add | w_cmp | w_and): w_next = S_GETA;
          default: begin
            w_next  = S_WAIT;
            illegal = 1'b1;
          end
        endcase
      end
      S_GETA: begin
        readnum = w_rn;
        loada   = 1'b1;
        w_next  = S_GETB;
      end
      S_GETB: begin
        readnum = w_rm;
        loadb   = 1'b1;
        w_next  = S_EXEC;
      end
      S_EXEC: begin
        ALU_op = w_movr ? 2'b00 : w_op;
        asel   = w_movr;
        loads  = !w_movr;
        if (w_cmp) begin
          done        = 1'b1;
          instr_ready = LP_B2B;
          w_next      = w_fin;
        end else begin
          loadc  = 1'b1;
          w_next = S_WRC;
        end
      end
      S_WRC: begin
        writenum    = w_rd;
        write       = 1'b1;
        done        = 1'b1;
        instr_ready = LP_B2B;
        w_next      = w_fin;
      end
      S_WIMM: begin
        writenum    = w_rn;
        vsel        = 2'b10;
        write       = 1'b1;
        done        = 1'b1;
        instr_ready = LP_B2B;
        w_next      = w_fin;
      end
      default: w_next = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Random + directed bench for alu_seq_ctrl against a per-cycle schedule model.
// Honours SEQ_BACK2BACK_EN the same way as the design.
module tb_alu_seq_ctrl;

`ifdef SEQ_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic        clk = 0;
  logic        rst_n = 0;
  logic [15:0] instr = '0;
  logic        instr_valid = 0;
  logic        instr_ready;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  vsel, ALU_op, shift;
  logic [15:0] sximm8;
  logic        done, illegal;

  alu_seq_ctrl #(.NREG(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .ALU_op(ALU_op),
    .shift(shift), .sximm8(sximm8), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy;
    logic [2:0] rn;
    logic [2:0] wn;
    logic       wr, la, lb, lc, ls, asl, bsl;
    logic [1:0] vs, op, sh;
    logic [15:0] sx;
    logic       dn, il;
  } frame_t;

  frame_t      sched[$];
  frame_t      exp;
  logic [15:0] cap = '0;
  bit          last_xfer;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  function automatic frame_t base(input logic [15:0] i);
    frame_t f;
    f = '0;
    f.sh = i[4:3];
    f.sx = {{8{i[7]}}, i[7:0]};
    return f;
  endfunction

  // Expected output frames for the cycles after a transfer.
  function automatic void build(input logic [15:0] i);
    frame_t f;
    logic [2:0] opc;
    logic [1:0] op;
    bit movi, movr, alu3, cmp, mvn;
    opc  = i[15:13];
    op   = i[12:11];
    movi = (opc == 3'b110) && (op == 2'b10);
    movr = (opc == 3'b110) && (op == 2'b00);
    cmp  = (opc == 3'b101) && (op == 2'b01);
    mvn  = (opc == 3'b101) && (op == 2'b11);
    alu3 = (opc == 3'b101) && (op != 2'b11);
    f = base(i);
    f.il = !(movi || movr || alu3 || mvn);
    sched.push_back(f);
    if (f.il) return;
    if (movi) begin
      f = base(i); f.wn = i[10:8]; f.vs = 2'b10;
      f.wr = 1; f.dn = 1; f.rdy = B2B;
      sched.push_back(f);
      return;
    end
    if (alu3) begin
      f = base(i); f.rn = i[10:8]; f.la = 1;
      sched.push_back(f);
    end
    f = base(i); f.rn = i[2:0]; f.lb = 1;
    sched.push_back(f);
    f = base(i);
    f.op  = movr ? 2'b00 : op;
    f.asl = movr;
    f.ls  = !movr;
    if (cmp) begin
      f.dn = 1; f.rdy = B2B;
      sched.push_back(f);
      return;
    end
    f.lc = 1;
    sched.push_back(f);
    f = base(i); f.wn = i[7:5]; f.wr = 1; f.dn = 1; f.rdy = B2B;
    sched.push_back(f);
  endfunction

  function automatic frame_t cur();
    frame_t f;
    if (sched.size() > 0) return sched[0];
    f = base(cap);
    f.rdy = 1;
    return f;
  endfunction

  function automatic frame_t dutf();
    frame_t f;
    f.rdy = instr_ready; f.rn = readnum; f.wn = writenum;
    f.wr = write; f.la = loada; f.lb = loadb; f.lc = loadc;
    f.ls = loads; f.asl = asel; f.bsl = bsel; f.vs = vsel;
    f.op = ALU_op; f.sh = shift; f.sx = sximm8;
    f.dn = done; f.il = illegal;
    return f;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc%0d got %h want %h", nm, cyc, act, req);
    end
  endtask

  task automatic cmp_frame();
    frame_t d;
    d = dutf();
    checks++;
    if (d !== exp) begin
      errors++;
      $display("FAIL frame cyc%0d got %h want %h", cyc, d, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    last_xfer = instr_valid && exp.rdy && rst_n;
    if (sched.size() > 0) void'(sched.pop_front());
    if (last_xfer) begin
      cap = instr;
      build(instr);
    end
    @(negedge clk);
    cyc++;
    exp = cur();
    cmp_frame();
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 20 && !exp.rdy; k++) step();
    chk("ready_timeout", {31'd0, exp.rdy}, 32'd1);
  endtask

  task automatic directed(input string nm, input logic [15:0] ins,
                          input int lat_req, input bit il_req,
                          input logic [2:0] wn_req,
                          input logic [15:0] sx_req);
    int lat;
    wait_ready();
    instr = ins;
    instr_valid = 1;
    step();
    instr_valid = 0;
    lat = 1;
    while (!(done || illegal) && lat < 12) begin
      step();
      lat++;
    end
    chk({nm, "_lat"}, lat, lat_req);
    chk({nm, "_ill"}, {31'd0, illegal}, {31'd0, il_req});
    chk({nm, "_wn"}, {29'd0, writenum}, {29'd0, wn_req});
    chk({nm, "_sx"}, {16'd0, sximm8}, {16'd0, sx_req});
  endtask

  initial begin
    logic [4:0] legal_ops [6];
    int n;
    bit pending;
    legal_ops = '{5'b11010, 5'b11000, 5'b10100,
                  5'b10101, 5'b10110, 5'b10111};
    exp = cur();
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_done", {31'd0, done | write | illegal}, 32'd0);
    rst_n = 1;
    @(negedge clk);
    exp = cur();
    cmp_frame();

    directed("movi5", 16'hD105, 2, 0, 3'd1, 16'h0005);
    directed("movif0", 16'hD1F0, 2, 0, 3'd1, 16'hFFF0);
    directed("add", 16'hA140, 5, 0, 3'd2, 16'h0040);
    directed("cmp", 16'hA900, 4, 0, 3'd0, 16'h0000);
    directed("mvn", 16'hB868, 4, 0, 3'd3, 16'h0068);
    directed("ill", 16'hE000, 1, 1, 3'd0, 16'h0000);

    // Reset while an ADD sits in GETB.
    wait_ready();
    instr = 16'hA140;
    instr_valid = 1;
    step();
    instr_valid = 0;
    step();
    step();
    chk("getb_loadb", {31'd0, loadb}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_mid_en",
        {26'd0, loada, loadb, loadc, loads, write, done}, 32'd0);
    sched.delete();
    cap = '0;
    exp = cur();
    step();
    step();
    rst_n = 1;
    repeat (6) step();

    // Held valid: MOV imm followed by ADD.
    wait_ready();
    instr = 16'hD105;
    instr_valid = 1;
    step();
    instr = 16'hA140;
    n = 1;
    while (!instr_ready && n < 10) begin
      step();
      n++;
    end
    chk("b2b_gap", n, B2B ? 2 : 3);
    step();
    chk("b2b_xfer", {31'd0, last_xfer}, 32'd1);
    instr_valid = 0;
    for (int k = 0; k < 10 && !done; k++) step();
    chk("b2b_add_done", {31'd0, done}, 32'd1);

    // Random traffic, instr held until accepted.
    pending = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pending) begin
        if ($urandom_range(0, 9) < 7)
          instr = {legal_ops[$urandom_range(0, 5)],
                   11'($urandom)};
        else
          instr = 16'($urandom);
        pending = 1;
      end
      instr_valid = ($urandom_range(0, 3) != 0);
      step();
      if (last_xfer) pending = 0;
    end
    instr_valid = 0;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
